// File: rtl/integer_alu_sched.sv
// Round-robin front end sharing one integer_alu core between requesters.
// Drives the core's start/ready/done handshake and routes results back.
module integer_alu_sched #(
    parameter int NREQ    = 4,
    parameter int OPW     = 32,
    parameter int CODEW   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OPW-1:0]   req_a,
    input  logic [NREQ*OPW-1:0]   req_b,
    input  logic [NREQ*CODEW-1:0] req_code,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [OPW-1:0]        rsp_data,
    output logic                  alu_start,
    output logic [OPW-1:0]        alu_a,
    output logic [OPW-1:0]        alu_b,
    output logic [CODEW-1:0]      alu_code,
    input  logic                  alu_ready,
    input  logic                  alu_done,
    input  logic [OPW-1:0]        alu_result,
    output logic                  stall,
    output logic [NREQ-1:0]       stall_owner
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [IW:0]     NREQ_W   = (IW+1)'(NREQ);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [IW-1:0]   grant;
    logic [IW:0]     sum;
    logic            any;
    logic [OPW-1:0]  result;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] grant_oh;
    logic [NREQ-1:0] owner_oh;
    logic            to_resp;

    // Round-robin pick: first pending requester above the last one served.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last} + (IW+1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!any && req_valid[sum[IW-1:0]]) begin
                any   = 1'b1;
                grant = sum[IW-1:0];
            end
        end
    end

    assign grant_oh  = ONE << grant;
    assign owner_oh  = ONE << owner;
    assign req_ready = (state == IDLE && any && !reset) ? grant_oh : '0;
    assign rsp_valid = (state == RESP) ? owner_oh : '0;
    assign rsp_data  = result;
    assign alu_start = (state == ISSUE);
    assign to_resp   = (state == ISSUE && alu_ready && alu_done) ||
                       (state == WAIT && alu_done);

    // Handshake FSM, operand/result latches and stall watchdog.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            last        <= LAST_RST;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_code    <= '0;
            result      <= '0;
            cnt         <= '0;
            stall       <= 1'b0;
            stall_owner <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        alu_a    <= req_a[int'(grant)*OPW +: OPW];
                        alu_b    <= req_b[int'(grant)*OPW +: OPW];
                        alu_code <= req_code[int'(grant)*CODEW +: CODEW];
                        owner    <= grant;
                        cnt      <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (alu_ready) begin
                        state <= alu_done ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (alu_done) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (to_resp) begin
                result <= alu_result;
            end
            // Counter saturates; the first stall keeps its owner.
            if ((state == ISSUE || state == WAIT) && !to_resp) begin
                if (cnt == CNT_MAX) begin
                    if (!stall) begin
                        stall       <= 1'b1;
                        stall_owner <= owner_oh;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_integer_alu_sched.sv
// Directed bench for integer_alu_sched with a small behavioural core.
// The core raises ready on the first start cycle and done core_lat cycles later.
module tb_integer_alu_sched;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [15:0]  req_code;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_data;
    logic         alu_start;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [3:0]   alu_code;
    logic         alu_ready;
    logic         alu_done;
    logic [31:0]  alu_result;
    logic         stall;
    logic [3:0]   stall_owner;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int core_lat  = 1;
    bit core_hang = 1'b0;

    integer_alu_sched #(
        .NREQ(4), .OPW(32), .CODEW(4), .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_code(req_code),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
        .alu_code(alu_code), .alu_ready(alu_ready), .alu_done(alu_done),
        .alu_result(alu_result), .stall(stall), .stall_owner(stall_owner)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_fn(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [3:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural core, updated just after each rising edge.
    initial begin
        int          wcnt;
        bit          busy;
        logic [31:0] res;
        alu_ready  = 1'b0;
        alu_done   = 1'b0;
        alu_result = '0;
        busy       = 1'b0;
        wcnt       = 0;
        res        = '0;
        forever begin
            @(posedge clock);
            #1;
            alu_ready = 1'b0;
            alu_done  = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else if (busy) begin
                if (!core_hang) begin
                    wcnt--;
                    if (wcnt <= 0) begin
                        alu_done   = 1'b1;
                        alu_result = res;
                        busy       = 1'b0;
                    end
                end
            end else if (alu_start) begin
                alu_ready = 1'b1;
                res = alu_fn(alu_a, alu_b, alu_code);
                if (core_lat == 0 && !core_hang) begin
                    alu_done   = 1'b1;
                    alu_result = res;
                end else begin
                    busy = 1'b1;
                    wcnt = core_lat;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] c);
        req_a[i*32 +: 32]  = a;
        req_b[i*32 +: 32]  = b;
        req_code[i*4 +: 4] = c;
    endtask

    // One full transaction from grant to response handshake.
    task automatic txn(input string nm, input int idx,
                       input logic [31:0] exp, input int lat);
        int         n;
        logic [3:0] g;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        g = req_ready;
        chk({nm, " grant"}, g, 64'(1) << idx);
        tick();
        req_valid = req_valid & ~g;
        n = 1;
        while (rsp_valid == 4'b0 && n < 40) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, n, lat + 2);
        chk({nm, " rsp_valid"}, rsp_valid, 64'(1) << idx);
        chk({nm, " rsp_data"}, rsp_data, exp);
        rsp_ready = rsp_valid;
        tick();
        rsp_ready = 4'b0;
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  code;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int early;
        vecs[0] = '{0, 32'hFFFF_FFFF, 32'd1,      4'd0, 0, 32'h0000_0000};
        vecs[1] = '{1, 32'd10,        32'd3,      4'd1, 2, 32'd7};
        vecs[2] = '{3, 32'h0000_F0F0, 32'h0FF0,   4'd2, 1, 32'h0000_00F0};
        vecs[3] = '{2, 32'h0000_00A5, 32'h005A,   4'd4, 0, 32'h0000_00FF};
        vecs[4] = '{1, 32'h0000_1200, 32'h0034,   4'd3, 4, 32'h0000_1234};

        reset     = 1'b1;
        req_valid = 4'b0;
        rsp_ready = 4'b0;
        req_a     = '0;
        req_b     = '0;
        req_code  = '0;
        tick();
        tick();
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_data", rsp_data, 0);
        chk("rst alu_start", alu_start, 0);
        chk("rst alu_ops", {alu_a, alu_b}, 0);
        chk("rst alu_code", alu_code, 0);
        chk("rst stall", {stall, stall_owner}, 0);
        reset = 1'b0;

        // Single request on 2, done three cycles after start.
        tick();
        core_lat = 3;
        set_req(2, 32'd5, 32'd7, 4'd0);
        req_valid = 4'b0100;
        #1;
        chk("t1 grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0;
        chk("t1 start", alu_start, 1);
        chk("t1 ops", {alu_a, alu_b}, {32'd5, 32'd7});
        chk("t1 code", alu_code, 0);
        tick();
        chk("t1 wait", {alu_start, rsp_valid}, 0);
        tick();
        tick();
        chk("t1 done cycle", rsp_valid, 0);
        tick();
        chk("t1 rsp_valid", rsp_valid, 4'b0100);
        chk("t1 rsp_data", rsp_data, 32'd12);
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = 4'b0;
        chk("t1 idle", rsp_valid, 0);

        // Table of single requests.
        for (int i = 0; i < 5; i++) begin
            core_lat = vecs[i].lat;
            set_req(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].code);
            req_valid = 4'b1 << vecs[i].idx;
            txn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].exp,
                vecs[i].lat);
        end

        // Backpressure with a wrong-owner rsp_ready and a pending request.
        core_lat = 1;
        set_req(0, 32'd100, 32'd23, 4'd1);
        set_req(1, 32'd3, 32'd4, 4'd0);
        req_valid = 4'b0001;
        #1;
        chk("bp grant", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        tick();
        tick();
        chk("bp rsp_valid", rsp_valid, 4'b0001);
        rsp_ready = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp hold", {rsp_valid, req_ready, rsp_data},
                {4'b0001, 4'b0000, 32'd77});
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0;
        chk("bp release", {rsp_valid, req_ready}, {4'b0000, 4'b0010});
        txn("bp next", 1, 32'd7, 1);

        // Fairness: after serving 2, pending 1 and 3 go 3 then 1.
        set_req(2, 32'd1, 32'd1, 4'd0);
        req_valid = 4'b0100;
        txn("fair 2", 2, 32'd2, 1);
        set_req(1, 32'd8, 32'd8, 4'd4);
        set_req(3, 32'd6, 32'd2, 4'd1);
        req_valid = 4'b1010;
        txn("fair 3", 3, 32'd4, 1);
        txn("fair 1", 1, 32'd0, 1);

        // Core that never completes trips the watchdog.
        core_hang = 1'b1;
        set_req(3, 32'd9, 32'd9, 4'd0);
        req_valid = 4'b1000;
        #1;
        chk("stall grant", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0001;
        chk("stall start", alu_start, 1);
        early = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (stall !== 1'b0 || stall_owner !== 4'b0) early++;
        end
        chk("stall early", early, 0);
        tick();
        chk("stall flag", stall, 1);
        chk("stall owner", stall_owner, 4'b1000);
        repeat (5) tick();
        chk("stall sticky", {stall, stall_owner, req_ready, rsp_valid},
            {1'b1, 4'b1000, 4'b0000, 4'b0000});

        // Reset while the core is stuck in WAIT.
        req_valid = 4'b1111;
        reset = 1'b1;
        tick();
        chk("rw ctl", {req_ready, rsp_valid, alu_start, alu_code,
                       stall, stall_owner}, 0);
        chk("rw ops", {alu_a, alu_b}, 0);
        chk("rw rsp_data", rsp_data, 0);
        tick();
        core_hang = 1'b0;
        core_lat  = 2;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 32'(10 + i), 32'(i), 4'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            txn($sformatf("all%0d", i), i, 32'(10 + 2 * i), 2);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
